// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
package aes_pkg;

    localparam int AES_NR     = 10;
    localparam int AES_NUM_RK = 11;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_rk_t;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_EXPAND,
        KS_DONE
    } ks_state_t;

endpackage

// File: rtl/aes_key_expand_ctrl_g_function.sv
// AES key-schedule g function: RotWord, SubWord, then XOR of the round constant.
module g_function
    import aes_pkg::*;
(
    input  aes_word_t   i_word,
    input  logic [3:0]  i_round,
    output aes_word_t   o_g
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    aes_word_t  w_rot;
    aes_word_t  w_sub;
    logic [7:0] w_rcon;

    assign w_rot = {i_word[23:0], i_word[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[gi*8 +: 8] = sbox(w_rot[gi*8 +: 8]);
        end
    endgenerate

    always_comb begin
        w_rcon = 8'h00;
        case (i_round)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    assign o_g = w_sub ^ {w_rcon, 24'h000000};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Iterative AES-128 key-schedule sequencer: one round key per cycle into an
// 11-entry round-key file with an indexed read port for the cipher controller.
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         keys_valid,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_err
);

    generate
        if (NUM_ROUNDS != AES_NR) begin : g_bad_rounds
            $error("aes_key_expand_ctrl: only NUM_ROUNDS=10 is supported");
        end
        if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_latency
            $error("aes_key_expand_ctrl: RD_LATENCY must be 0 or 1");
        end
    endgenerate

    ks_state_t  r_state;
    ks_state_t  w_state_next;
    logic [3:0] r_rcnt;
    logic [3:0] w_rcnt_next;
    logic       w_accept;

    // Round-key file; deliberately not reset, keys_valid qualifies its contents.
    aes_rk_t    r_rk [0:AES_NUM_RK-1];

    aes_rk_t    w_cur;
    aes_word_t  w_g;
    aes_word_t  w_w4, w_w5, w_w6, w_w7;

    assign w_accept = key_valid && key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= KS_IDLE;
            r_rcnt  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_rcnt  <= w_rcnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rcnt_next  = r_rcnt;
        key_ready    = 1'b0;
        busy         = 1'b0;
        keys_valid   = 1'b0;
        case (r_state)
            KS_IDLE, KS_DONE: begin
                key_ready  = 1'b1;
                keys_valid = (r_state == KS_DONE);
                if (key_valid) begin
                    w_state_next = KS_EXPAND;
                    w_rcnt_next  = 4'd0;
                end
            end
            KS_EXPAND: begin
                busy = 1'b1;
                if (r_rcnt == 4'(AES_NR - 1)) begin
                    w_state_next = KS_DONE;
                    w_rcnt_next  = 4'd0;
                end else begin
                    w_rcnt_next  = r_rcnt + 4'd1;
                end
            end
            default: begin
                w_state_next = KS_IDLE;
                w_rcnt_next  = 4'd0;
            end
        endcase
    end

    assign w_cur = r_rk[r_rcnt];

    g_function u_g_function (
        .i_word  (w_cur[31:0]),
        .i_round (r_rcnt),
        .o_g     (w_g)
    );

    assign w_w4 = w_cur[127:96] ^ w_g;
    assign w_w5 = w_cur[95:64]  ^ w_w4;
    assign w_w6 = w_cur[63:32]  ^ w_w5;
    assign w_w7 = w_cur[31:0]   ^ w_w6;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_accept) begin
                r_rk[0] <= key_in;
            end else if (r_state == KS_EXPAND) begin
                r_rk[r_rcnt + 4'd1] <= {w_w4, w_w5, w_w6, w_w7};
            end
        end
    end

    logic    w_rd_err;
    aes_rk_t w_rd_data;

    assign w_rd_err  = (rk_rd_idx > 4'(AES_NUM_RK - 1));
    assign w_rd_data = w_rd_err ? '0 : r_rk[rk_rd_idx];

    // No write bypass: a same-edge write is seen on the following read.
    generate
        if (RD_LATENCY == 1) begin : g_rd_reg
            aes_rk_t r_rd_data;
            logic    r_rd_err;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                    r_rd_err  <= 1'b0;
                end else begin
                    r_rd_data <= w_rd_data;
                    r_rd_err  <= w_rd_err;
                end
            end
            assign rk_rd_data = r_rd_data;
            assign rk_rd_err  = r_rd_err;
        end else begin : g_rd_comb
            assign rk_rd_data = w_rd_data;
            assign rk_rd_err  = w_rd_err;
        end
    endgenerate

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Self-checking bench for aes_key_expand_ctrl against a word-level FIPS-197 key-schedule model.
module tb_aes_key_expand_ctrl;

    typedef logic [0:10][127:0] sched_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic         key_ready;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         keys_valid;
    logic [3:0]   rk_rd_idx = 4'd0;
    logic [127:0] rk_rd_data;
    logic         rk_rd_err;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    always #5 clk = ~clk;

    aes_key_expand_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .busy       (busy),
        .keys_valid (keys_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data),
        .rk_rd_err  (rk_rd_err)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_tab [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = (aa[7]) ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    function automatic sched_t key_sched(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        sched_t      r;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]], sbox_tab[t[31:24]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 11; n++) r[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
        return r;
    endfunction

    // Model: the file fills one entry per cycle after an accepted key.
    sched_t       m_sched;
    logic [127:0] m_file [0:10];
    bit           m_known [0:10];
    int           m_fill = -1;      // -1: nothing in flight, 0..9: entries being filled, 10: complete
    bit           m_started = 1'b0;
    logic         exp_busy, exp_ready, exp_kv, exp_err, exp_known;
    logic [127:0] exp_data;

    initial begin
        for (int i = 0; i < 11; i++) begin
            m_file[i] = '0;
            m_known[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            if (rst) begin
                m_fill = -1;
                exp_data = '0;
                exp_err = 1'b0;
                exp_known = 1'b1;
                for (int i = 0; i < 11; i++) m_known[i] = 1'b0;
                m_started = 1'b1;
            end else if (m_started) begin
                exp_err = (rk_rd_idx > 4'd10);
                if (exp_err) begin
                    exp_data = '0;
                    exp_known = 1'b1;
                end else begin
                    exp_data = m_file[rk_rd_idx];
                    exp_known = m_known[rk_rd_idx];
                end
                if ((m_fill == -1 || m_fill == 10) && key_valid) begin
                    m_sched = key_sched(key_in);
                    for (int i = 0; i < 11; i++) m_known[i] = 1'b0;
                    m_file[0] = key_in;
                    m_known[0] = 1'b1;
                    m_fill = 0;
                end else if (m_fill >= 0 && m_fill < 10) begin
                    m_file[m_fill+1] = m_sched[m_fill+1];
                    m_known[m_fill+1] = 1'b1;
                    m_fill++;
                end
            end
            exp_busy  = (m_fill >= 0 && m_fill < 10);
            exp_ready = !exp_busy;
            exp_kv    = (m_fill == 10);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                check("busy", 128'(busy), 128'(exp_busy));
                check("key_ready", 128'(key_ready), 128'(exp_ready));
                check("keys_valid", 128'(keys_valid), 128'(exp_kv));
                check("rk_rd_err", 128'(rk_rd_err), 128'(exp_err));
                if (exp_known) check("rk_rd_data", rk_rd_data, exp_data);
            end
        end
    end

    bit rand_idx = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rand_idx) rk_rd_idx = 4'($urandom_range(0, 15));
        end
    end

    // ---------------- directed helpers (all act at negedges) ----------------
    task automatic send_key(input logic [127:0] k);
        int n = 0;
        while (!key_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL send_key: key_ready got 0 expected 1 within 100 cycles");
        end
        key_valid = 1'b1;
        key_in = k;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int bc = 0;
        while (busy && bc < 100) begin
            bc++;
            @(negedge clk);
        end
        check({nm, " busy_cycles"}, 128'(bc), 128'(10));
        check({nm, " keys_valid_after_T+10"}, 128'(keys_valid), 128'(1));
    endtask

    task automatic read_rk(input int idx, output logic [127:0] d, output logic e);
        rk_rd_idx = 4'(idx);
        @(negedge clk);
        d = rk_rd_data;
        e = rk_rd_err;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sched_t       s;
        logic [127:0] d, k1, k2;
        logic         e;

        build_sbox();
        s = key_sched(FIPS_KEY);
        check("model fips rk1", s[1], FIPS_RK1);
        check("model fips rk10", s[10], FIPS_RK10);
        s = key_sched('0);
        check("model zero rk1", s[1], ZERO_RK1);
        check("model zero rk10", s[10], ZERO_RK10);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset key_ready", 128'(key_ready), 128'(1));
        check("reset busy", 128'(busy), 128'(0));
        check("reset keys_valid", 128'(keys_valid), 128'(0));
        check("reset rk_rd_data", rk_rd_data, '0);
        check("reset rk_rd_err", 128'(rk_rd_err), 128'(0));
        rst = 1'b0;

        send_key(FIPS_KEY);
        wait_done("fips");
        read_rk(1, d, e);
        check("fips rk1", d, FIPS_RK1);
        read_rk(10, d, e);
        check("fips rk10", d, FIPS_RK10);

        send_key('0);
        wait_done("zero");
        read_rk(0, d, e);
        check("zero rk0", d, '0);
        read_rk(1, d, e);
        check("zero rk1", d, ZERO_RK1);
        read_rk(10, d, e);
        check("zero rk10", d, ZERO_RK10);

        // key_valid held high with a different key throughout EXPAND
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key_valid = 1'b1;
        key_in = k1;
        @(posedge clk);
        @(negedge clk);
        key_in = k2;
        for (int i = 0; i < 10; i++) begin
            check("hold key_ready", 128'(key_ready), 128'(0));
            @(negedge clk);
        end
        key_valid = 1'b0;
        check("hold keys_valid", 128'(keys_valid), 128'(1));
        s = key_sched(k1);
        read_rk(10, d, e);
        check("hold rk10 from first key", d, s[10]);

        // new key accepted in DONE
        send_key(k2);
        check("restart keys_valid drop", 128'(keys_valid), 128'(0));
        wait_done("restart");
        s = key_sched(k2);
        read_rk(10, d, e);
        check("restart rk10", d, s[10]);

        // reset during the 5th EXPAND cycle
        send_key(k1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst keys_valid", 128'(keys_valid), 128'(0));
        check("midrst key_ready", 128'(key_ready), 128'(1));
        rst = 1'b0;
        send_key(FIPS_KEY);
        wait_done("after_rst");
        read_rk(10, d, e);
        check("after_rst rk10", d, FIPS_RK10);

        // index sweep
        s = key_sched(FIPS_KEY);
        for (int i = 0; i < 16; i++) begin
            read_rk(i, d, e);
            check($sformatf("sweep rk%0d data", i), d, (i <= 10) ? s[i] : '0);
            check($sformatf("sweep rk%0d err", i), 128'(e), (i <= 10) ? 128'(0) : 128'(1));
        end

        // back-to-back keys, zero gap in DONE, random reads under way
        rand_idx = 1'b1;
        for (int n = 0; n < 3; n++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            send_key(k1);
            wait_done($sformatf("b2b%0d", n));
        end
        rand_idx = 1'b0;
        s = key_sched(k1);
        for (int i = 0; i < 11; i++) begin
            read_rk(i, d, e);
            check($sformatf("b2b final rk%0d", i), d, s[i]);
        end

        // random keys with random idle gaps
        rand_idx = 1'b1;
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            send_key({$urandom, $urandom, $urandom, $urandom});
            wait_done($sformatf("rand%0d", n));
        end
        rand_idx = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_key_expand_ctrl.md
Name: aes_key_expand_ctrl

Overview:
Iterative AES-128 key-schedule sequencer. Accepts a 128-bit cipher key through a valid/ready handshake. Drives the shared g_function datapath with a round counter and produces one round key per cycle. All 11 round keys (rk0..rk10) are held in a register file, which the cipher round controller reads through an indexed read port.

Parameters:
NUM_ROUNDS, 10, number of expansion rounds; only 10 (AES-128) is supported, and any other value is an elaboration error.
RD_LATENCY, 1, read-port latency in cycles; legal values are 0 (combinational) or 1 (registered).

Ports:
clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  synchronous, active-high reset.
key_valid  in  1  key_in is valid this cycle.
key_ready  out  1  block can accept a key; high in IDLE and DONE.
key_in  in  128  cipher key; byte 0 is in [127:120].
busy  out  1  high while in EXPAND.
keys_valid  out  1  all 11 round keys are stored and stable.
rk_rd_idx  in  4  round-key index, 0..10.
rk_rd_data  out  128  round key at rk_rd_idx, available after RD_LATENCY.
rk_rd_err  out  1  rk_rd_idx > 10; aligned with rk_rd_data.

Behaviour:
- States: IDLE, EXPAND, DONE.
- Reset values: state=IDLE, round counter rcnt=0, key_ready=1, busy=0, keys_valid=0, rk_rd_data=0, rk_rd_err=0.
- Reset does not clear the round-key file. keys_valid=0 gates its use.
- Accept: a handshake occurs when key_valid && key_ready.
  - On the handshake edge: rk[0] <= key_in, rcnt <= 0, state <= EXPAND, keys_valid <= 0.
- EXPAND, each cycle:
  - W = rk[rcnt][31:0] (last word) feeds g_function, with rounds=rcnt.
  - w4 = rk[rcnt][127:96] ^ g_out.
  - w5 = rk[rcnt][95:64] ^ w4.
  - w6 = rk[rcnt][63:32] ^ w5.
  - w7 = rk[rcnt][31:0] ^ w6.
  - rk[rcnt+1] <= {w4,w5,w6,w7}; rcnt <= rcnt+1.
  - When rcnt==9, after writing rk[10]: state <= DONE, keys_valid <= 1, rcnt <= 0.
- Latency: the handshake is at edge T. rk[n] is written at edge T+n. keys_valid rises at edge T+10, so it is visible in the cycle after edge T+10. busy is high for exactly 10 cycles.
- In EXPAND, key_ready=0 and key_valid is ignored. No abort input exists; only rst aborts.
- In DONE, keys are held indefinitely. A new handshake in DONE restarts as from IDLE: keys_valid drops on the same edge.
- Reset mid-EXPAND: next cycle state is IDLE, keys_valid=0, and partial keys are discarded logically.
- Read port:
  - RD_LATENCY=1: rk_rd_data <= rk[rk_rd_idx] each cycle, with index 11..15 returning 0 and rk_rd_err=1.
  - Reads are permitted in any state. Data is defined only when keys_valid=1, or when the index is already written in the current expansion.
  - A read of an index being written on the same edge returns the old value (no bypass).
- The rcnt to Rcon mapping is owned by g_function. rcnt=0 selects Rcon 0x01 and rcnt=9 selects 0x36.

Decomposition:
- Shared package aes_pkg holds:
  - localparam AES_NR=10 and AES_NUM_RK=11.
  - typedef aes_word_t (logic [31:0]) and aes_rk_t (logic [127:0]).
  - typedef enum ks_state_t {KS_IDLE, KS_EXPAND, KS_DONE}.
- One sub-module: the existing g_function, instantiated once and shared across all 10 rounds.
- S-box instances stay inside g_function. No other sub-modules.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, handshake at edge T:
  - keys_valid=1 after edge T+10.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - busy high for exactly 10 cycles.
- All-zero key:
  - rk0=0.
  - rk1=62636363626363636263636362636363.
  - rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid held high throughout EXPAND with a different key: ignored (key_ready=0), and the results match the first key. A new key in DONE: keys_valid falls on the handshake edge, then the second key's schedule completes 10 cycles later.
- rst asserted at the 5th EXPAND cycle: next cycle IDLE, keys_valid=0, key_ready=1. Re-issuing the FIPS key yields the correct rk10.
- Read port with RD_LATENCY=1: idx sweep 0..15 → rk0..rk10 one cycle later. idx 11..15 → data 0, rk_rd_err=1.
- Back-to-back keys with a 0-cycle gap in DONE over 3 keys: each schedule is correct, with no stale words from the previous key.
